// File: rtl/updownstream_proc.sv
// updownstream_proc: per-client exposure/limit checker for CPU orders and exchange releases.
// Exchange releases in the same cycle as an order on the same client are applied before the order is evaluated.
module updownstream_proc (
    input  logic        clk,
    input  logic        HRESETn,
    input  logic        cpu_go,
    input  logic        cpu_new_max,
    input  logic [4:0]  cpu_client_id,
    input  logic [31:0] cpu_amount,
    input  logic        exchange_go,
    input  logic [4:0]  exchange_client_id,
    input  logic [15:0] exchange_amount,
    output logic [31:0] accumulated_orders,
    output logic [15:0] cancelled_orders,
    output logic        cpu_accept,
    output logic        cpu_reject
);
    logic [31:0] limit_q [32];
    logic [31:0] exposure_q [32];
    logic [31:0] acc_q, acc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        accept_q, reject_q;
    logic [31:0] ex_cur, ex_rel, exp_prime;
    logic [32:0] sum, acc_sum;
    logic        order, ok;

    always_comb begin
        ex_cur    = exposure_q[exchange_client_id];
        ex_rel    = (ex_cur > {16'b0, exchange_amount}) ? ex_cur - {16'b0, exchange_amount} : '0;
        exp_prime = (exchange_go && exchange_client_id == cpu_client_id) ? ex_rel : exposure_q[cpu_client_id];
        sum       = {1'b0, exp_prime} + {1'b0, cpu_amount};
        order     = cpu_go && !cpu_new_max;
        ok        = sum <= {1'b0, limit_q[cpu_client_id]};
        acc_sum   = {1'b0, acc_q} + {1'b0, cpu_amount};
        acc_d     = (order && ok) ? (acc_sum[32] ? '1 : acc_sum[31:0]) : acc_q;
        cnt_d     = (order && !ok && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    // the order write comes last so it overrides the release on a shared client; exp_prime already includes it
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 32; i++) begin
                limit_q[i]    <= '0;
                exposure_q[i] <= '0;
            end
            acc_q    <= '0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            if (exchange_go)
                exposure_q[exchange_client_id] <= ex_rel;
            if (cpu_go && cpu_new_max)
                limit_q[cpu_client_id] <= cpu_amount;
            if (order)
                exposure_q[cpu_client_id] <= ok ? sum[31:0] : exp_prime;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            accept_q <= order && ok;
            reject_q <= order && !ok;
        end
    end

    assign accumulated_orders = acc_q;
    assign cancelled_orders   = cnt_q;
    assign cpu_accept         = accept_q;
    assign cpu_reject         = reject_q;
endmodule

// File: tb/tb_updownstream_proc.sv
// tb_updownstream_proc: directed tests for updownstream_proc with hand-computed expectations.
module tb_updownstream_proc;
    logic        clk = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cpu_go = 1'b0, cpu_new_max = 1'b0;
    logic [4:0]  cpu_client_id = '0;
    logic [31:0] cpu_amount = '0;
    logic        exchange_go = 1'b0;
    logic [4:0]  exchange_client_id = '0;
    logic [15:0] exchange_amount = '0;
    logic [31:0] accumulated_orders;
    logic [15:0] cancelled_orders;
    logic        cpu_accept, cpu_reject;
    int n_tests = 0, n_fail = 0;

    updownstream_proc dut (
        .clk(clk), .HRESETn(HRESETn), .cpu_go(cpu_go), .cpu_new_max(cpu_new_max),
        .cpu_client_id(cpu_client_id), .cpu_amount(cpu_amount), .exchange_go(exchange_go),
        .exchange_client_id(exchange_client_id), .exchange_amount(exchange_amount),
        .accumulated_orders(accumulated_orders), .cancelled_orders(cancelled_orders),
        .cpu_accept(cpu_accept), .cpu_reject(cpu_reject)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_go = 1'b0;
        cpu_new_max = 1'b0;
        exchange_go = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        HRESETn = 1'b0;
        step();
        HRESETn = 1'b1;
        step();
    endtask

    task automatic set_limit(input logic [4:0] id, input logic [31:0] amt);
        cpu_go = 1'b1; cpu_new_max = 1'b1; cpu_client_id = id; cpu_amount = amt;
        step();
        idle();
    endtask

    task automatic order(input logic [4:0] id, input logic [31:0] amt);
        cpu_go = 1'b1; cpu_new_max = 1'b0; cpu_client_id = id; cpu_amount = amt;
        step();
        idle();
    endtask

    task automatic release_exp(input logic [4:0] id, input logic [15:0] amt);
        exchange_go = 1'b1; exchange_client_id = id; exchange_amount = amt;
        step();
        idle();
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        #2;
        n_tests++; if (accumulated_orders !== 32'd0) begin n_fail++; $display("FAIL reset_acc got %h exp 0", accumulated_orders); end
        n_tests++; if (cancelled_orders !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0", cancelled_orders); end
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got %b exp 00", {cpu_accept, cpu_reject}); end
        apply_reset();
    endtask

    task automatic test_no_limit();
        order(5'd3, 32'd10);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b01) begin n_fail++; $display("FAIL nolimit_pulse got %b exp 01", {cpu_accept, cpu_reject}); end
        n_tests++; if (cancelled_orders !== 16'd1) begin n_fail++; $display("FAIL nolimit_cnt got %0d exp 1", cancelled_orders); end
        n_tests++; if (accumulated_orders !== 32'd0) begin n_fail++; $display("FAIL nolimit_acc got %0d exp 0", accumulated_orders); end
        step();
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b00) begin n_fail++; $display("FAIL pulse_width got %b exp 00", {cpu_accept, cpu_reject}); end
        order(5'd3, 32'd0);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b10) begin n_fail++; $display("FAIL zero_order got %b exp 10", {cpu_accept, cpu_reject}); end
    endtask

    task automatic test_limit_orders();
        apply_reset();
        set_limit(5'd3, 32'd100);
        n_tests++; if ({cpu_accept, cpu_reject, cancelled_orders, accumulated_orders} !== 50'd0) begin n_fail++; $display("FAIL setlimit_quiet got %b/%b/%0d/%0d exp all 0", cpu_accept, cpu_reject, cancelled_orders, accumulated_orders); end
        order(5'd3, 32'd60);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b10) begin n_fail++; $display("FAIL order60 got %b exp 10", {cpu_accept, cpu_reject}); end
        order(5'd3, 32'd40);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b10) begin n_fail++; $display("FAIL order40 got %b exp 10", {cpu_accept, cpu_reject}); end
        order(5'd3, 32'd1);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b01) begin n_fail++; $display("FAIL order1 got %b exp 01", {cpu_accept, cpu_reject}); end
        n_tests++; if (accumulated_orders !== 32'd100) begin n_fail++; $display("FAIL limit_acc got %0d exp 100", accumulated_orders); end
        n_tests++; if (cancelled_orders !== 16'd1) begin n_fail++; $display("FAIL limit_cnt got %0d exp 1", cancelled_orders); end
        set_limit(5'd3, 32'd101);
        order(5'd3, 32'd1);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b10) begin n_fail++; $display("FAIL exposure100 got %b exp 10", {cpu_accept, cpu_reject}); end
        n_tests++; if (accumulated_orders !== 32'd101) begin n_fail++; $display("FAIL limit_acc2 got %0d exp 101", accumulated_orders); end
    endtask

    task automatic test_same_cycle();
        set_limit(5'd5, 32'd50);
        order(5'd5, 32'd50);
        cpu_go = 1'b1; cpu_new_max = 1'b0; cpu_client_id = 5'd5; cpu_amount = 32'd20;
        exchange_go = 1'b1; exchange_client_id = 5'd5; exchange_amount = 16'd20;
        step();
        idle();
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b10) begin n_fail++; $display("FAIL same_cycle got %b exp 10", {cpu_accept, cpu_reject}); end
        order(5'd5, 32'd1);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b01) begin n_fail++; $display("FAIL same_cycle_exp got %b exp 01", {cpu_accept, cpu_reject}); end
        order(5'd5, 32'd0);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b10) begin n_fail++; $display("FAIL same_cycle_zero got %b exp 10", {cpu_accept, cpu_reject}); end
    endtask

    task automatic test_clamp();
        set_limit(5'd7, 32'd10);
        order(5'd7, 32'd10);
        release_exp(5'd7, 16'hFFFF);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b00) begin n_fail++; $display("FAIL exch_quiet got %b exp 00", {cpu_accept, cpu_reject}); end
        order(5'd7, 32'd10);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b10) begin n_fail++; $display("FAIL clamp got %b exp 10", {cpu_accept, cpu_reject}); end
    endtask

    task automatic test_lower_limit();
        set_limit(5'd8, 32'd100);
        order(5'd8, 32'd80);
        set_limit(5'd8, 32'd50);
        release_exp(5'd8, 16'd20);
        order(5'd8, 32'd0);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b01) begin n_fail++; $display("FAIL lowered_60 got %b exp 01", {cpu_accept, cpu_reject}); end
        release_exp(5'd8, 16'd10);
        order(5'd8, 32'd0);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b10) begin n_fail++; $display("FAIL lowered_50 got %b exp 10", {cpu_accept, cpu_reject}); end
        order(5'd8, 32'd1);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b01) begin n_fail++; $display("FAIL lowered_51 got %b exp 01", {cpu_accept, cpu_reject}); end
    endtask

    task automatic test_newmax_exchange();
        set_limit(5'd9, 32'd20);
        order(5'd9, 32'd20);
        cpu_go = 1'b1; cpu_new_max = 1'b1; cpu_client_id = 5'd9; cpu_amount = 32'd30;
        exchange_go = 1'b1; exchange_client_id = 5'd9; exchange_amount = 16'd5;
        step();
        idle();
        order(5'd9, 32'd15);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b10) begin n_fail++; $display("FAIL newmax_exch got %b exp 10", {cpu_accept, cpu_reject}); end
        order(5'd9, 32'd1);
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b01) begin n_fail++; $display("FAIL newmax_exch_full got %b exp 01", {cpu_accept, cpu_reject}); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_p [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        set_limit(5'd11, 32'd3);
        for (int i = 0; i < 5; i++) begin
            cpu_go = 1'b1; cpu_new_max = 1'b0; cpu_client_id = 5'd11; cpu_amount = 32'd1;
            step();
            n_tests++; if ({cpu_accept, cpu_reject} !== exp_p[i]) begin n_fail++; $display("FAIL b2b_%0d got %b exp %b", i, {cpu_accept, cpu_reject}, exp_p[i]); end
        end
        idle();
        step();
        n_tests++; if ({cpu_accept, cpu_reject} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle got %b exp 00", {cpu_accept, cpu_reject}); end
    endtask

    task automatic test_saturation();
        apply_reset();
        set_limit(5'd0, 32'hFFFF_FFFF);
        set_limit(5'd1, 32'hFFFF_FFFF);
        order(5'd0, 32'h8000_0000);
        n_tests++; if (accumulated_orders !== 32'h8000_0000) begin n_fail++; $display("FAIL sat_acc1 got %h exp 80000000", accumulated_orders); end
        order(5'd1, 32'h8000_0001);
        n_tests++; if (accumulated_orders !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_acc2 got %h exp ffffffff", accumulated_orders); end
        order(5'd1, 32'd5);
        n_tests++; if ({cpu_accept, accumulated_orders} !== {1'b1, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL sat_acc_hold got %b/%h exp 1/ffffffff", cpu_accept, accumulated_orders); end
        cpu_go = 1'b1; cpu_new_max = 1'b0; cpu_client_id = 5'd10; cpu_amount = 32'd1;
        repeat (65534) @(posedge clk);
        #1;
        n_tests++; if (cancelled_orders !== 16'hFFFE) begin n_fail++; $display("FAIL sat_cnt1 got %h exp fffe", cancelled_orders); end
        step();
        n_tests++; if (cancelled_orders !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt2 got %h exp ffff", cancelled_orders); end
        step();
        step();
        idle();
        n_tests++; if ({cpu_reject, cancelled_orders} !== {1'b1, 16'hFFFF}) begin n_fail++; $display("FAIL sat_cnt_hold got %b/%h exp 1/ffff", cpu_reject, cancelled_orders); end
    endtask

    task automatic test_async_reset();
        cpu_go = 1'b1; cpu_new_max = 1'b0; cpu_client_id = 5'd1; cpu_amount = 32'd1;
        #2;
        HRESETn = 1'b0;
        #1;
        n_tests++; if ({accumulated_orders, cancelled_orders, cpu_accept, cpu_reject} !== 50'd0) begin n_fail++; $display("FAIL async_rst got %h/%h/%b/%b exp all 0", accumulated_orders, cancelled_orders, cpu_accept, cpu_reject); end
        step();
        n_tests++; if ({accumulated_orders, cancelled_orders, cpu_accept, cpu_reject} !== 50'd0) begin n_fail++; $display("FAIL rst_ignore got %h/%h/%b/%b exp all 0", accumulated_orders, cancelled_orders, cpu_accept, cpu_reject); end
        idle();
        #2;
        HRESETn = 1'b1;
        step();
        order(5'd3, 32'd10);
        n_tests++; if ({cpu_accept, cpu_reject, cancelled_orders} !== {2'b01, 16'd1}) begin n_fail++; $display("FAIL post_rst got %b/%0d exp 01/1", {cpu_accept, cpu_reject}, cancelled_orders); end
    endtask

    initial begin
        test_reset();
        test_no_limit();
        test_limit_orders();
        test_same_cycle();
        test_clamp();
        test_lower_limit();
        test_newmax_exchange();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
